serial_tx_framer: RTL and testbench
===================================

# serial_tx_framer

Frames parallel words into an asynchronous serial bitstream: start bit, WIDTH data bits LSB-first, optional parity bit, one or two stop bits. Each bit is held for a programmable number of clock cycles. It sits downstream of the producer logic and drives the serial line. Internally it uses a right-shifting data register whose LSB is the serial bit, with the same bit ordering as the team's shift register in DIR=0 mode. Words arrive through a valid/ready handshake.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- CLKS_PER_BIT, 16, clock cycles each bit is held on `tx` (≥2)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits (1 or 2)
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (any state except IDLE)
- done  output  1  one-cycle pulse when the final stop bit completes

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - tx=1, in_ready=1, busy=0.
  - On in_valid & in_ready at a rising edge, capture in_data into the shift register and compute the parity bit from in_data (even: XOR of bits; odd: inverted XOR).
  - Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0.
  - After each CLKS_PER_BIT cycles, shift right by one and increment the bit index.
  - After WIDTH bits, go to PAR if PARITY≠0, else STOP.
- PAR: tx = captured parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - Then go to IDLE with done=1 for exactly that first IDLE cycle.
- Bit timer:
  - Counter runs 0..CLKS_PER_BIT−1, width $clog2(CLKS_PER_BIT).
  - The bit boundary is the terminal count; the counter wraps to 0.
  - The counter is cleared on acceptance.
- Bit index: counts 0..WIDTH−1, width $clog2(WIDTH)+1, cleared on entry to DATA.
- in_data and in_valid are ignored outside IDLE. The captured word is unaffected by later changes on in_data.
- PARITY values other than 0/1/2, or STOP_BITS other than 1/2, are a configuration error and need not be handled.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, tx=1, busy=0, done=0, in_ready=1 once rst_n is high. Counters and shift register are 0.
- Reset mid-frame aborts the frame immediately: tx returns to 1 without waiting for a clock edge, and no done pulse is generated.
- Accept at edge k: tx=0 and busy=1 from edge k onward (registered outputs).
- Frame length from acceptance edge to the done edge: (1+WIDTH+(PARITY≠0)+STOP_BITS)×CLKS_PER_BIT cycles.
- done and in_ready are both high in the cycle after the frame ends.
- If in_valid is held high, the next word is accepted at the next edge. This gives a minimum of one idle cycle (tx=1) between frames.
- All outputs are registered except in_ready, which is decoded from the state register.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → tx=1, in_ready=1, busy=0, done=0; no transitions on tx for 20 idle cycles.
- Basic frame (WIDTH=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1): send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses 40 cycles after acceptance.
- Parity: send 0xA5 with PARITY=1 → parity bit 0, frame 44 cycles. Send 0xA5 with PARITY=2 → parity bit 1. Send 0x07 with PARITY=1 → parity bit 1.
- Back-to-back: hold in_valid=1 with 0x3C then 0xC3 → second acceptance occurs exactly 1 cycle after done; both frames bit-exact; exactly 2 done pulses.
- Mid-frame changes: change in_data and toggle in_valid during DATA → transmitted word unchanged; in_ready stays 0 until done.
- Reset mid-frame: assert rst_n=0 during bit 3 of DATA → tx=1 asynchronously; no done pulse; a new frame of 0x55 after release transmits correctly.

Source files
------------

// File: rtl/serial_tx_framer.sv
// Async serial framer: start bit, WIDTH data bits LSB-first, optional parity, 1-2 stop bits.
// Accepts one word per frame via valid/ready; tx, busy and done are registered.
module serial_tx_framer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(WIDTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic             HAS_PAR   = (PARITY != 0);
  localparam logic             ODD_PAR   = (PARITY == 2);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             stop_q;
  logic [WIDTH-1:0] shreg_q;
  logic             par_q;
  logic             par_d;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  // The bit timer wraps at terminal count, so every state shares one boundary strobe.
  assign bit_end = (cnt_q == CNT_LAST);
  assign cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
  assign par_d   = (^in_data) ^ ODD_PAR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shreg_q <= in_data;
            par_q   <= par_d;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end

        S_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            idx_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (idx_q == IDX_LAST) begin
              if (HAS_PAR) begin
                tx_q    <= par_q;
                state_q <= S_PAR;
              end else begin
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              // tx is registered, so it takes the bit that becomes LSB after this shift.
              idx_q <= idx_q + IDX_W'(1);
              tx_q  <= shreg_q[1];
            end
          end
        end

        S_PAR: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: four configurations checked each cycle against a frame-level model.
module tb_serial_tx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din [4];
  logic       vld [4];
  logic       rdy_w [4];
  logic       tx_w [4];
  logic       busy_w [4];
  logic       done_w [4];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int cpb_m [4]  = '{4, 4, 4, 3};
  int par_m [4]  = '{0, 1, 2, 1};
  int stop_m [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  serial_tx_framer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  serial_tx_framer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  serial_tx_framer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vld[2]),
    .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  serial_tx_framer #(.WIDTH(8), .CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(din[3]), .in_valid(vld[3]),
    .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: a frame is a list of bit values, each lasting cpb cycles from the acceptance edge.
  logic [15:0] mf [4];
  int          mt [4];
  int          mlen [4];
  bit          mact [4];
  logic        e_tx [4];
  logic        e_done [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      mact[i] = 1'b0; e_tx[i] = 1'b1; e_done[i] = 1'b0; mt[i] = 0; mlen[i] = 0; mf[i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 4; i++) begin
        e_done[i] = 1'b0;
        if (!rst_n) begin
          mact[i] = 1'b0;
        end else if (mact[i]) begin
          mt[i]++;
          if (mt[i] == mlen[i]) begin
            mact[i]   = 1'b0;
            e_done[i] = 1'b1;
          end
        end else if (vld[i]) begin
          int nb;
          mf[i] = '0;
          nb = 1;
          for (int b = 0; b < 8; b++) begin
            mf[i][nb] = din[i][b];
            nb++;
          end
          if (par_m[i] != 0) begin
            mf[i][nb] = (^din[i]) ^ (par_m[i] == 2);
            nb++;
          end
          for (int s = 0; s < stop_m[i]; s++) begin
            mf[i][nb] = 1'b1;
            nb++;
          end
          mlen[i] = nb * cpb_m[i];
          mt[i]   = 0;
          mact[i] = 1'b1;
        end
        e_tx[i] = mact[i] ? mf[i][mt[i] / cpb_m[i]] : 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("u%0d.tx", i), tx_w[i], e_tx[i]);
          check($sformatf("u%0d.busy", i), busy_w[i], mact[i]);
          check($sformatf("u%0d.done", i), done_w[i], e_done[i]);
          check($sformatf("u%0d.in_ready", i), rdy_w[i], !mact[i]);
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] d);
    @(negedge clk);
    din[i] = d;
    vld[i] = 1'b1;
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  // Samples each bit mid-period and returns cycles from acceptance edge to done edge.
  task automatic wait_frame(input int i, input bit disturb, output int lat,
                            output logic [15:0] bits, output int rdy_bad);
    lat = -1;
    bits = '0;
    rdy_bad = 0;
    for (int m = 1; m <= 200; m++) begin
      @(negedge clk);
      if (disturb) begin
        if (m >= 8 && m <= 20) begin
          din[i] = 8'($urandom);
          vld[i] = (m % 2 == 1);
        end else if (m == 21) begin
          vld[i] = 1'b0;
        end
      end
      if (m >= 2 && (m - 2) % cpb_m[i] == 0 && (m - 2) / cpb_m[i] < 16)
        bits[(m - 2) / cpb_m[i]] = tx_w[i];
      if (done_w[i]) begin
        lat = m;
        break;
      end
      if (rdy_w[i]) rdy_bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          rbad;
    int          dcnt;
    int          md;
    int          ma;
    int          toggles;
    logic        rdy_at_done;
    logic        prev_tx;
    logic [15:0] bits;

    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      vld[i] = 1'b0;
    end

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.tx", tx_w[0], 1'b1);
    check("reset.in_ready", rdy_w[0], 1'b1);
    check("reset.busy", busy_w[0], 1'b0);
    check("reset.done", done_w[0], 1'b0);
    chk_en = 1'b1;
    toggles = 0;
    prev_tx = tx_w[0];
    repeat (20) begin
      @(negedge clk);
      if (tx_w[0] != prev_tx) toggles++;
      prev_tx = tx_w[0];
    end
    check("idle.tx_toggles", toggles, 0);

    // Basic frame 0xA5, no parity
    send(0, 8'hA5);
    check("basic.busy_at_accept", busy_w[0], 1'b1);
    check("basic.tx_at_accept", tx_w[0], 1'b0);
    wait_frame(0, 1'b0, lat, bits, rbad);
    check("basic.latency", lat, 40);
    check("basic.bits", bits[9:0], 10'b1101001010);
    check("basic.ready_low", rbad, 0);

    // Parity variants
    send(1, 8'hA5);
    wait_frame(1, 1'b0, lat, bits, rbad);
    check("even_a5.latency", lat, 44);
    check("even_a5.parity", bits[9], 1'b0);
    send(2, 8'hA5);
    wait_frame(2, 1'b0, lat, bits, rbad);
    check("odd_a5.parity", bits[9], 1'b1);
    check("odd_a5.stop", bits[10], 1'b1);
    send(1, 8'h07);
    wait_frame(1, 1'b0, lat, bits, rbad);
    check("even_07.parity", bits[9], 1'b1);

    // Two stop bits, 3 clocks per bit
    send(3, 8'h5A);
    wait_frame(3, 1'b0, lat, bits, rbad);
    check("stop2.latency", lat, 36);
    check("stop2.bits", bits[11:0], 12'b110010110100);

    // Back-to-back with in_valid held high
    @(negedge clk);
    din[0] = 8'h3C;
    vld[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'hC3;
    dcnt = 0;
    md = -1;
    ma = -1;
    rdy_at_done = 1'b0;
    for (int m = 1; m <= 120; m++) begin
      @(negedge clk);
      if (done_w[0]) begin
        dcnt++;
        if (md < 0) begin
          md = m;
          rdy_at_done = rdy_w[0];
        end
      end
      if (md >= 0 && ma < 0 && busy_w[0]) begin
        ma = m;
        vld[0] = 1'b0;
      end
    end
    vld[0] = 1'b0;
    check("b2b.done_count", dcnt, 2);
    check("b2b.first_done", md, 40);
    check("b2b.gap", ma - md, 1);
    check("b2b.ready_with_done", rdy_at_done, 1'b1);

    // Input changes during DATA
    send(0, 8'h96);
    wait_frame(0, 1'b1, lat, bits, rbad);
    check("midframe.latency", lat, 40);
    check("midframe.word", bits[8:1], 8'h96);
    check("midframe.ready_low", rbad, 0);

    // Reset during data bit 3
    send(0, 8'hF0);
    repeat (17) @(negedge clk);
    check("rst_mid.tx_before", tx_w[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.tx_async", tx_w[0], 1'b1);
    check("rst_mid.busy_async", busy_w[0], 1'b0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_w[0]) dcnt++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done_w[0]) dcnt++;
    end
    check("rst_mid.no_done", dcnt, 0);
    send(0, 8'h55);
    wait_frame(0, 1'b0, lat, bits, rbad);
    check("after_rst.latency", lat, 40);
    check("after_rst.bits", bits[9:0], 10'b1010101010);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
